jtdd_rom_arb: RTL

- Shares one ROM/SDRAM read channel between two requesters: the object line engine (slot 0) and a tile layer fetcher (slot 1).
- Each slot keeps a one-entry address/data cache.
- A slot's ok is asserted only while its cached address matches its current request.
- The block sits between the video layers and the frame's SDRAM bank port. It sequences fetches so that neither layer sees data that belongs to the other layer or to a stale address.

---
 rtl/jtdd_arb_pkg.sv | 12 +
 rtl/jtdd_rom_arb_if.sv | 42 ++++
 rtl/jtdd_arb_slot.sv | 44 ++++
 rtl/jtdd_rom_arb.sv | 112 +++++++++++
 4 files changed

// File: rtl/jtdd_arb_pkg.sv
// Shared definitions for the ROM arbiter: FSM encoding and slot index width.
package jtdd_arb_pkg;

  localparam int SLOT_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/jtdd_rom_arb_if.sv
// Bus bundle between two requesters, the arbiter and the ROM port.
//
// Handshake: a requester raises csN with addrN and keeps addrN steady until
// okN; okN is only high while the cached tag equals the current addrN, so it
// may be consumed in the same cycle it is seen. On the ROM side rom_cs and
// rom_addr are held until rom_ok is accepted; rom_ok seen in the first cycle
// after a new address is treated as belonging to the previous access.
interface jtdd_rom_arb_if #(
  parameter int AW = 19,
  parameter int DW = 16
);
  import jtdd_arb_pkg::*;

  logic              cs0;
  logic [AW-1:0]     addr0;
  logic [DW-1:0]     data0;
  logic              ok0;
  logic              cs1;
  logic [AW-1:0]     addr1;
  logic [DW-1:0]     data1;
  logic              ok1;
  logic              rom_cs;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              rom_ok;
  // Debug view of the arbiter FSM and the slot currently owning the ROM.
  arb_state_t        st;
  logic [SLOT_W-1:0] grant;

  // Requesters and ROM side.
  modport master (
    output cs0, addr0, cs1, addr1, rom_data, rom_ok,
    input  data0, ok0, data1, ok1, rom_cs, rom_addr, st, grant
  );

  // Arbiter side.
  modport slave (
    input  cs0, addr0, cs1, addr1, rom_data, rom_ok,
    output data0, ok0, data1, ok1, rom_cs, rom_addr, st, grant
  );

endinterface

// File: rtl/jtdd_arb_slot.sv
// One-entry address/data cache for a single requester slot.
module jtdd_arb_slot
  import jtdd_arb_pkg::*;
#(
  parameter int AW = 19,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  output logic          ok,
  output logic [DW-1:0] data,
  output logic          miss
);

  logic [AW-1:0] tag;
  logic [DW-1:0] dat;
  logic          valid;
  logic          hit;

  // Cache entry: written only by the arbiter when a fetch for this slot lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      dat   <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      dat   <= wr_data;
    end
  end

  // Compare against the live address so ok tracks addr changes immediately.
  assign hit  = valid && (addr == tag);
  assign ok   = cs && hit;
  assign miss = cs && !hit;
  assign data = dat;

endmodule

// File: rtl/jtdd_rom_arb.sv
// Two-slot ROM read arbiter: object engine on slot 0, tile fetcher on slot 1.
module jtdd_rom_arb
  import jtdd_arb_pkg::*;
#(
  parameter int AW = 19,
  parameter int DW = 16,
  parameter int RR = 1
) (
  input  logic           clk,
  input  logic           rst,
  jtdd_rom_arb_if.slave  bus
);

  arb_state_t        st, st_nx;
  logic [SLOT_W-1:0] win, win_nx;
  logic [SLOT_W-1:0] last, last_nx;
  logic              rom_cs_q, rom_cs_nx;
  logic [AW-1:0]     rom_addr_q, rom_addr_nx;
  logic [AW-1:0]     flight_tag, flight_tag_nx;
  logic              wr_en;
  logic              wr0, wr1;
  logic              miss0, miss1;

  jtdd_arb_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .cs      (bus.cs0),
    .addr    (bus.addr0),
    .wr      (wr0),
    .wr_tag  (flight_tag),
    .wr_data (bus.rom_data),
    .ok      (bus.ok0),
    .data    (bus.data0),
    .miss    (miss0)
  );

  jtdd_arb_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .cs      (bus.cs1),
    .addr    (bus.addr1),
    .wr      (wr1),
    .wr_tag  (flight_tag),
    .wr_data (bus.rom_data),
    .ok      (bus.ok1),
    .data    (bus.data1),
    .miss    (miss1)
  );

  // FSM and ROM port registers; reset drops rom_cs without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      win        <= '0;
      last       <= SLOT_W'(1);
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      flight_tag <= '0;
    end else begin
      st         <= st_nx;
      win        <= win_nx;
      last       <= last_nx;
      rom_cs_q   <= rom_cs_nx;
      rom_addr_q <= rom_addr_nx;
      flight_tag <= flight_tag_nx;
    end
  end

  // Grant selection, fetch sequencing and cache write strobe.
  always_comb begin
    st_nx         = st;
    win_nx        = win;
    last_nx       = last;
    rom_cs_nx     = rom_cs_q;
    rom_addr_nx   = rom_addr_q;
    flight_tag_nx = flight_tag;
    wr_en         = 1'b0;
    case (st)
      ST_IDLE: begin
        if (miss0 || miss1) begin
          win_nx = miss0 ? '0 : SLOT_W'(1);
          if (miss0 && miss1 && (RR != 0)) win_nx = ~last;
          rom_addr_nx   = (win_nx == '0) ? bus.addr0 : bus.addr1;
          flight_tag_nx = rom_addr_nx;
          rom_cs_nx     = 1'b1;
          st_nx         = ST_SETTLE;
        end
      end
      // rom_ok here may still refer to the previous address.
      ST_SETTLE: st_nx = ST_WAIT;
      ST_WAIT: begin
        if (bus.rom_ok) begin
          wr_en     = 1'b1;
          rom_cs_nx = 1'b0;
          last_nx   = win;
          st_nx     = ST_IDLE;
        end
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  // The landed data goes under the in-flight tag, not the slot's live address.
  assign wr0 = wr_en && (win == '0);
  assign wr1 = wr_en && (win != '0);

  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.st       = st;
  assign bus.grant    = win;

endmodule
